fp16_lane_serializer: RTL and testbench
=======================================

Name: fp16_lane_serializer

Overview:
Upstream feeder for the fp16-to-fp32 converter. It accepts packed words of LANES fp16 values with a valid/ready handshake and emits one fp16 value per cycle, in lane order, on a second valid/ready stream. The output fp16 value drives the converter's fp16 input directly. The block adds word buffering, partial-word support through a lane count, and end-of-stream (last) tracking.

Parameters:
LANES, 4, number of fp16 lanes per input word (>=2)
CNT_W, $clog2(LANES+1), width of the lane-count field (derived; not overridden)
IDX_W, $clog2(LANES), width of the lane index (derived; not overridden)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
in_valid_i  in  1  input word valid
in_ready_o  out  1  input word accepted when in_valid_i && in_ready_o
in_data_i  in  16*LANES  packed fp16; lane k = bits [16k+15:16k]
in_count_i  in  CNT_W  number of valid lanes, starting at lane 0
in_last_i  in  1  word is the final word of the stream
out_valid_o  out  1  out_fp16_o valid
out_ready_i  in  1  downstream accepts when out_valid_o && out_ready_i
out_fp16_o  out  16  current fp16 value, routed to the converter input
out_lane_o  out  IDX_W  lane index of out_fp16_o
out_last_o  out  1  current value is the final lane of a last word
last_dropped_o  out  1  one-cycle pulse: a last word with count 0 was accepted

Behaviour:
- Reset is asynchronous and active-low; all state clears immediately on rst_ni low.
- Reset values: state EMPTY, buffer 0, lane index 0, stored count 0, stored last 0. Outputs: out_valid_o=0, out_fp16_o=0, out_lane_o=0, out_last_o=0, last_dropped_o=0, in_ready_o=1 once out of reset.
- Count rules:
  - in_count_i > LANES is clamped to LANES at capture.
  - in_count_i = 0: the word is consumed in the acceptance cycle with no output; state is unchanged.
  - If that zero-count word has in_last_i=1, last_dropped_o pulses in the next cycle.
- State machine:
  - EMPTY: in_ready_o=1, out_valid_o=0. On accept with count>0: capture data, clamped count and last; set lane index to 0; go to BUSY.
  - BUSY: out_valid_o=1, out_fp16_o = buffer lane[idx], out_lane_o = idx.
  - out_last_o = stored last && (idx == count-1).
  - On an output handshake with idx < count-1: increment idx.
  - On an output handshake with idx == count-1 (final lane):
    - if in_valid_i and count>0: capture the new word and stay in BUSY (back-to-back).
    - if in_valid_i and count=0: consume the word, no output, go to EMPTY.
    - if in_valid_i is low: go to EMPTY.
- in_ready_o = (state==EMPTY) || (state==BUSY && out_ready_i && idx==count-1). This is the only combinational ready path from output to input.
- Latency: a word accepted in cycle t shows lane 0 valid in cycle t+1.
- Throughput: one fp16 per cycle under continuous out_ready_i. There are no bubbles between words.
- Stall: while out_valid_o && !out_ready_i, out_fp16_o, out_lane_o and out_last_o hold stable and the buffer does not change.
- Data is passed bit-exact; there is no fp interpretation (NaN, Inf and subnormal patterns are untouched).
- Reset asserted mid-word: the buffered word is discarded and no output follows after reset.

Test Plan:
- LANES=4. Word 0x3C00_4000_C000_0001, count 4, last 1, out_ready_i=1 -> outputs 0x0001, 0xC000, 0x4000, 0x3C00 with lanes 0..3 in consecutive cycles starting at t+1. out_last_o=1 only on 0x3C00.
- Two full words back-to-back, out_ready_i=1 -> 8 consecutive valid outputs with no bubble. in_ready_o is high in the cycle of lane 3 of word 0.
- Word with count 2, then out_ready_i toggled 1,0,0,1 -> lane0 is emitted. Lane1 value is held stable for two cycles, then emitted. The block returns to EMPTY.
- Count 0 with last 1 -> no out_valid_o. last_dropped_o=1 for exactly one cycle. in_ready_o stays 1.
- Count 7 with LANES=4 -> clamped: exactly 4 outputs.
- rst_ni pulsed low asynchronously (between clock edges) while lane 1 of 4 is pending -> out_valid_o=0 immediately. No further outputs. in_ready_o=1 after release.

Source files
------------

// File: rtl/fp16_lane_serializer.sv
// fp16_lane_serializer: takes packed words of LANES fp16 values and emits one
// fp16 value per cycle in lane order. It supports partial words through a lane
// count and tracks the end of the stream. Data is passed bit-exact.
module fp16_lane_serializer #(
  parameter int LANES = 4,
  parameter int CNT_W = $clog2(LANES + 1),
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [16*LANES-1:0]   in_data_i,
  input  logic [CNT_W-1:0]      in_count_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [15:0]           out_fp16_o,
  output logic [IDX_W-1:0]      out_lane_o,
  output logic                  out_last_o,
  output logic                  last_dropped_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_e;

  state_e              state_q;
  logic [16*LANES-1:0] buf_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                last_q;
  logic                drop_q;

  logic [CNT_W-1:0]    cnt_d;
  logic                zero_cnt;
  logic                final_lane;
  logic                out_hs;
  logic                accept;
  logic                busy;
  logic [15:0]         lane_w [LANES];

  // Unpack the buffered word into individual fp16 lanes for the output mux.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_w[gi] = buf_q[16*gi +: 16];
    end
  endgenerate

  // Handshake decode. in_ready_o only depends on out_ready_i when the final
  // lane of the buffered word is being handed off, so a new word can be
  // captured in the same edge and no bubble appears between words.
  always_comb begin
    cnt_d      = (in_count_i > CNT_W'(LANES)) ? CNT_W'(LANES) : in_count_i;
    zero_cnt   = (in_count_i == '0);
    busy       = (state_q == BUSY);
    final_lane = ((CNT_W'(idx_q) + CNT_W'(1)) == cnt_q);
    out_hs     = busy && out_ready_i;
    in_ready_o = !busy || (out_hs && final_lane);
    accept     = in_valid_i && in_ready_o;
  end

  // Output view of the buffer; idle outputs are forced to zero.
  always_comb begin
    out_valid_o    = busy;
    out_fp16_o     = busy ? lane_w[idx_q] : 16'h0000;
    out_lane_o     = busy ? idx_q : '0;
    out_last_o     = busy && last_q && final_lane;
    last_dropped_o = drop_q;
  end

  // Control FSM with word buffer, lane index and drop pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      buf_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      // A zero-count word is consumed without output. If it closes the
      // stream, downstream is told through a one-cycle pulse.
      drop_q <= accept && zero_cnt && in_last_i;
      case (state_q)
        EMPTY: begin
          if (accept && !zero_cnt) begin
            buf_q   <= in_data_i;
            cnt_q   <= cnt_d;
            last_q  <= in_last_i;
            idx_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (out_ready_i) begin
            if (!final_lane) begin
              idx_q <= idx_q + IDX_W'(1);
            end else if (accept && !zero_cnt) begin
              buf_q  <= in_data_i;
              cnt_q  <= cnt_d;
              last_q <= in_last_i;
              idx_q  <= '0;
            end else begin
              idx_q   <= '0;
              state_q <= EMPTY;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_lane_serializer.sv
// Directed testbench for fp16_lane_serializer with LANES=4.
module tb_fp16_lane_serializer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] in_data_i;
  logic [2:0]  in_count_i;
  logic        in_last_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_fp16_o;
  logic [1:0]  out_lane_o;
  logic        out_last_o;
  logic        last_dropped_o;

  int checks = 0;
  int errors = 0;

  fp16_lane_serializer #(.LANES(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data_i),
    .in_count_i     (in_count_i),
    .in_last_i      (in_last_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_fp16_o     (out_fp16_o),
    .out_lane_o     (out_lane_o),
    .out_last_o     (out_last_o),
    .last_dropped_o (last_dropped_o)
  );

  always #5 clk_i = ~clk_i;

  // One directed single-word case; exp_vals holds the expected outputs in
  // emission order, first output in the low 16 bits.
  typedef struct {
    logic [63:0] data;
    logic [2:0]  cnt;
    logic        last;
    int          n;
    logic [63:0] exp_vals;
    int          last_lane;
    logic        drop;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] exp_a [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vecs[0] = '{64'h3C00_4000_C000_0001, 3'd4, 1'b1, 4, 64'h3C00_4000_C000_0001,  3, 1'b0};
    vecs[1] = '{64'h7C00_FC00_7E01_0400, 3'd2, 1'b0, 2, 64'h0000_0000_7E01_0400, -1, 1'b0};
    vecs[2] = '{64'h1111_2222_3333_8001, 3'd7, 1'b1, 4, 64'h1111_2222_3333_8001,  3, 1'b0};
    vecs[3] = '{64'hAAAA_BBBB_CCCC_DDDD, 3'd0, 1'b1, 0, 64'h0000_0000_0000_0000, -1, 1'b1};
    vecs[4] = '{64'h9999_0000_FFFF_0000, 3'd3, 1'b1, 3, 64'h0000_0000_FFFF_0000,  2, 1'b0};
    vecs[5] = '{64'h1234_5678_9ABC_DEF0, 3'd1, 1'b1, 1, 64'h0000_0000_0000_DEF0,  0, 1'b0};
    vecs[6] = '{64'h0102_0304_0506_0708, 3'd5, 1'b0, 4, 64'h0102_0304_0506_0708, -1, 1'b0};
    exp_a = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
              16'h0005, 16'h0006, 16'h0007, 16'h0008};

    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_count_i  = '0;
    in_last_i   = 1'b0;
    out_ready_i = 1'b1;

    // Reset state
    #3;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_fp16", out_fp16_o, 0);
    chk("rst_lane", out_lane_o, 0);
    chk("rst_last", out_last_o, 0);
    chk("rst_drop", last_dropped_o, 0);
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    tick();
    #1 chk("rst_ready", in_ready_o, 1);
    $display("reset: released");

    // Table-driven single words with continuous out_ready_i
    for (int i = 0; i < 7; i++) begin
      tick();
      in_valid_i = 1'b1;
      in_data_i  = vecs[i].data;
      in_count_i = vecs[i].cnt;
      in_last_i  = vecs[i].last;
      #1;
      chk($sformatf("v%0d_ready", i), in_ready_o, 1);
      chk($sformatf("v%0d_idle", i), out_valid_o, 0);
      tick();
      in_valid_i = 1'b0;
      #1;
      chk($sformatf("v%0d_drop", i), last_dropped_o, vecs[i].drop);
      for (int k = 0; k < vecs[i].n; k++) begin
        chk($sformatf("v%0d_k%0d_valid", i, k), out_valid_o, 1);
        chk($sformatf("v%0d_k%0d_fp16", i, k), out_fp16_o, vecs[i].exp_vals[16*k +: 16]);
        chk($sformatf("v%0d_k%0d_lane", i, k), out_lane_o, k);
        chk($sformatf("v%0d_k%0d_last", i, k), out_last_o, (k == vecs[i].last_lane));
        tick();
        #1;
      end
      if (vecs[i].n == 0) begin
        tick();
        #1;
      end
      chk($sformatf("v%0d_end_valid", i), out_valid_o, 0);
      chk($sformatf("v%0d_end_drop", i), last_dropped_o, 0);
      chk($sformatf("v%0d_end_ready", i), in_ready_o, 1);
      $display("vector %0d: data %h count %0d last %0b -> %0d outputs",
               i, vecs[i].data, vecs[i].cnt, vecs[i].last, vecs[i].n);
    end

    // Two full words back-to-back, no bubble
    tick();
    in_valid_i = 1'b1;
    in_data_i  = 64'h0004_0003_0002_0001;
    in_count_i = 3'd4;
    in_last_i  = 1'b0;
    #1 chk("b2b_ready0", in_ready_o, 1);
    tick();
    in_data_i = 64'h0008_0007_0006_0005;
    in_last_i = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b_k%0d_valid", k), out_valid_o, 1);
      chk($sformatf("b2b_k%0d_fp16", k), out_fp16_o, exp_a[k]);
      chk($sformatf("b2b_k%0d_lane", k), out_lane_o, k % 4);
      chk($sformatf("b2b_k%0d_last", k), out_last_o, (k == 7));
      chk($sformatf("b2b_k%0d_ready", k), in_ready_o, (k == 3 || k == 7));
      tick();
      if (k == 3) in_valid_i = 1'b0;
      #1;
    end
    chk("b2b_end_valid", out_valid_o, 0);
    $display("sequence back-to-back: 8 outputs");

    // Count 2 with out_ready_i toggled 1,0,0,1
    tick();
    in_valid_i = 1'b1;
    in_data_i  = 64'h0000_0000_ABCD_1234;
    in_count_i = 3'd2;
    in_last_i  = 1'b1;
    #1;
    tick();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    #1;
    chk("stall_l0_fp16", out_fp16_o, 16'h1234);
    chk("stall_l0_lane", out_lane_o, 0);
    chk("stall_l0_last", out_last_o, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      out_ready_i = 1'b0;
      #1;
      chk($sformatf("stall_c%0d_valid", c), out_valid_o, 1);
      chk($sformatf("stall_c%0d_fp16", c), out_fp16_o, 16'hABCD);
      chk($sformatf("stall_c%0d_lane", c), out_lane_o, 1);
      chk($sformatf("stall_c%0d_last", c), out_last_o, 1);
      chk($sformatf("stall_c%0d_ready", c), in_ready_o, 0);
    end
    tick();
    out_ready_i = 1'b1;
    #1;
    chk("stall_go_fp16", out_fp16_o, 16'hABCD);
    chk("stall_go_ready", in_ready_o, 1);
    tick();
    #1;
    chk("stall_end_valid", out_valid_o, 0);
    chk("stall_end_ready", in_ready_o, 1);
    $display("sequence stall: count 2 with ready 1,0,0,1");

    // Asynchronous reset while lane 1 of 4 is pending
    tick();
    in_valid_i = 1'b1;
    in_data_i  = 64'h4444_3333_2222_1111;
    in_count_i = 3'd4;
    in_last_i  = 1'b1;
    #1;
    tick();
    in_valid_i = 1'b0;
    #1;
    chk("arst_l0_fp16", out_fp16_o, 16'h1111);
    tick();
    #1;
    chk("arst_l1_fp16", out_fp16_o, 16'h2222);
    chk("arst_l1_valid", out_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", out_valid_o, 0);
    chk("arst_fp16", out_fp16_o, 0);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      chk($sformatf("arst_post%0d_valid", c), out_valid_o, 0);
      chk($sformatf("arst_post%0d_ready", c), in_ready_o, 1);
    end
    $display("sequence async reset: word discarded");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
